// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one input bit per clock).
// Registered bcd/blank/overflow are held between conversions for direct display drive.
module bin2bcd_seq #(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic [DIGITS-1:0]     blank,
   output logic                  overflow
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
   localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(BIN_W - 1);
   localparam logic [DIGITS-1:0] BLANK_RST = ~(DIGITS'(1));

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t             state_q, state_d;
   logic [BIN_W-1:0]   shreg_q, shreg_d;
   logic [BCD_W-1:0]   work_q, work_d;
   logic               ovf_acc_q, ovf_acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [BCD_W-1:0]   bcd_q, bcd_d;
   logic [DIGITS-1:0]  blank_q, blank_d;
   logic               ovf_q, ovf_d;
   logic               done_q, done_d;

   logic [BCD_W-1:0]   adj;
   logic [BCD_W-1:0]   shift_work;
   logic               shift_ovf;
   logic [DIGITS-1:0]  blank_fin;
   logic               zero_above;

   // Add-3 correction on every digit in parallel, then the shifted working value.
   always_comb begin
      adj = work_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (work_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
      end
      shift_work = {adj[BCD_W-2:0], shreg_q[BIN_W-1]};
      shift_ovf  = ovf_acc_q | adj[BCD_W-1];
   end

   // Leading-zero mask: a digit blanks only if it and every digit above it is zero.
   always_comb begin
      blank_fin  = '0;
      zero_above = 1'b1;
      for (int i = DIGITS - 1; i > 0; i--) begin
         zero_above   = zero_above & (shift_work[4*i +: 4] == 4'd0);
         blank_fin[i] = zero_above & ~shift_ovf;
      end
   end

   // NOTE: every next-state signal takes a default first so no path leaves it unassigned (no latches).
   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      work_d    = work_q;
      ovf_acc_d = ovf_acc_q;
      cnt_d     = cnt_q;
      bcd_d     = bcd_q;
      blank_d   = blank_q;
      ovf_d     = ovf_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               shreg_d   = bin;
               work_d    = '0;
               ovf_acc_d = 1'b0;
               cnt_d     = '0;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            shreg_d   = shreg_q << 1;
            work_d    = shift_work;
            ovf_acc_d = shift_ovf;
            cnt_d     = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
               state_d = IDLE;
               bcd_d   = shift_work;
               ovf_d   = shift_ovf;
               blank_d = blank_fin;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         shreg_q   <= '0;
         work_q    <= '0;
         ovf_acc_q <= 1'b0;
         cnt_q     <= '0;
         bcd_q     <= '0;
         blank_q   <= BLANK_RST;
         ovf_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         work_q    <= work_d;
         ovf_acc_q <= ovf_acc_d;
         cnt_q     <= cnt_d;
         bcd_q     <= bcd_d;
         blank_q   <= blank_d;
         ovf_q     <= ovf_d;
         done_q    <= done_d;
      end
   end

   assign busy     = (state_q == SHIFT);
   assign done     = done_q;
   assign bcd      = bcd_q;
   assign blank    = blank_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Testbench for bin2bcd_seq: default 8-bit/3-digit instance plus a 10-bit/3-digit
// instance for the overflow cases.
module tb_bin2bcd_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        start8, start10;
   logic [7:0]  bin8;
   logic [9:0]  bin10;
   logic        busy8, done8, ovf8, busy10, done10, ovf10;
   logic [11:0] bcd8, bcd10;
   logic [2:0]  blank8, blank10;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) dut (
      .clk(clk), .reset(reset), .start(start8), .bin(bin8),
      .busy(busy8), .done(done8), .bcd(bcd8), .blank(blank8), .overflow(ovf8)
   );

   bin2bcd_seq #(.BIN_W(10), .DIGITS(3)) dut10 (
      .clk(clk), .reset(reset), .start(start10), .bin(bin10),
      .busy(busy10), .done(done10), .bcd(bcd10), .blank(blank10), .overflow(ovf10)
   );

   typedef struct {
      bit          use10;
      logic [9:0]  bin;
      logic [11:0] bcd;
      logic [2:0]  blank;
      logic        ovf;
   } vec_t;

   vec_t tbl[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Launch one conversion, wait (bounded) for done, check latency, busy length and outputs.
   task automatic convert(input bit use10, input logic [9:0] b, input logic [11:0] e_bcd,
                          input logic [2:0] e_blank, input logic e_ovf, input string name);
      int lat;
      int busy_n;
      int exp_lat;
      exp_lat = use10 ? 10 : 8;
      @(negedge clk);
      if (use10) begin start10 = 1'b1; bin10 = b; end
      else       begin start8  = 1'b1; bin8  = b[7:0]; end
      @(posedge clk); #1;
      start8 = 1'b0; start10 = 1'b0;
      lat = 0; busy_n = 0;
      while (!(use10 ? done10 : done8) && lat < 30) begin
         if (use10 ? busy10 : busy8) busy_n++;
         @(posedge clk); #1;
         lat++;
      end
      check({name, " latency"}, lat, exp_lat);
      check({name, " busy cycles"}, busy_n, exp_lat);
      check({name, " busy in done cycle"}, use10 ? busy10 : busy8, 0);
      check({name, " bcd"}, use10 ? bcd10 : bcd8, e_bcd);
      check({name, " blank"}, use10 ? blank10 : blank8, e_blank);
      check({name, " overflow"}, use10 ? ovf10 : ovf8, e_ovf);
      @(posedge clk); #1;
      check({name, " done one cycle"}, use10 ? done10 : done8, 0);
   endtask

   initial begin
      int gap;
      int seen;
      int d2, d1, d0;
      logic [2:0] e_bl;

      tbl[0] = '{0, 10'd0,    12'h000, 3'b110, 1'b0};
      tbl[1] = '{0, 10'd255,  12'h255, 3'b000, 1'b0};
      tbl[2] = '{0, 10'd42,   12'h042, 3'b100, 1'b0};
      tbl[3] = '{0, 10'd7,    12'h007, 3'b110, 1'b0};
      tbl[4] = '{0, 10'd100,  12'h100, 3'b000, 1'b0};
      tbl[5] = '{1, 10'd1023, 12'h023, 3'b000, 1'b1};
      tbl[6] = '{1, 10'd999,  12'h999, 3'b000, 1'b0};
      tbl[7] = '{1, 10'd1000, 12'h000, 3'b000, 1'b1};
      tbl[8] = '{1, 10'd5,    12'h005, 3'b110, 1'b0};
      tbl[9] = '{0, 10'd10,   12'h010, 3'b100, 1'b0};

      reset = 1'b1; start8 = 1'b0; start10 = 1'b0; bin8 = '0; bin10 = '0;
      repeat (2) @(posedge clk);
      @(negedge clk); reset = 1'b0;
      @(posedge clk); #1;
      check("reset busy", busy8, 0);
      check("reset done", done8, 0);
      check("reset bcd", bcd8, 12'h000);
      check("reset blank", blank8, 3'b110);
      check("reset overflow", ovf8, 0);

      for (int i = 0; i < 10; i++)
         convert(tbl[i].use10, tbl[i].bin, tbl[i].bcd, tbl[i].blank, tbl[i].ovf, $sformatf("vec%0d", i));

      // Start pulse and bin change mid-conversion are ignored; previous bcd (010) held.
      @(negedge clk); start8 = 1'b1; bin8 = 8'd100;
      @(posedge clk); #1; start8 = 1'b0;
      gap = 0; seen = 0;
      while (!done8 && gap < 30) begin
         if (gap == 2) begin start8 = 1'b1; bin8 = 8'd9; end
         if (gap == 3) start8 = 1'b0;
         if (bcd8 !== 12'h010) seen++;
         @(posedge clk); #1;
         gap++;
      end
      check("midstart held bcd", seen, 0);
      check("midstart latency", gap, 8);
      check("midstart bcd", bcd8, 12'h100);
      check("midstart blank", blank8, 3'b000);
      @(posedge clk); #1;
      check("midstart no restart", busy8, 0);

      // Reset at cycle 4 of a conversion of 200 aborts it.
      @(negedge clk); start8 = 1'b1; bin8 = 8'd200;
      @(posedge clk); #1; start8 = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      check("abort busy before reset", busy8, 1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("abort busy", busy8, 0);
      check("abort done", done8, 0);
      check("abort bcd", bcd8, 12'h000);
      check("abort blank", blank8, 3'b110);
      seen = 0;
      repeat (12) begin @(posedge clk); #1; if (done8) seen++; end
      check("abort no done", seen, 0);
      convert(0, 10'd200, 12'h200, 3'b000, 1'b0, "after abort");

      // Reset and start in the same cycle: reset wins.
      @(negedge clk); reset = 1'b1; start8 = 1'b1; bin8 = 8'd55;
      @(posedge clk);
      @(negedge clk); reset = 1'b0; start8 = 1'b0;
      @(posedge clk); #1;
      check("reset+start busy", busy8, 0);
      check("reset+start bcd", bcd8, 12'h000);

      // Exhaustive back-to-back: next start is driven in each done cycle.
      @(negedge clk); start8 = 1'b1; bin8 = 8'd0;
      @(posedge clk); #1; start8 = 1'b0;
      for (int v = 0; v < 256; v++) begin
         gap = 0;
         while (!done8 && gap < 30) begin
            @(posedge clk); #1;
            gap++;
         end
         d2 = v / 100; d1 = (v / 10) % 10; d0 = v % 10;
         e_bl = {d2 == 0, (d2 == 0) && (d1 == 0), 1'b0};
         check($sformatf("b2b %0d gap", v), gap, 8);
         check($sformatf("b2b %0d bcd", v), bcd8, {20'd0, d2[3:0], d1[3:0], d0[3:0]});
         check($sformatf("b2b %0d blank", v), blank8, e_bl);
         check($sformatf("b2b %0d overflow", v), ovf8, 0);
         if (v < 255) begin
            start8 = 1'b1; bin8 = 8'(v + 1);
            @(posedge clk); #1;
            start8 = 1'b0;
         end
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
